// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared quadrature direction codes and helpers
//
// Purpose: direction-code type and constants shared between the quadrature
// decoder and its consumers (position tracker, velocity window).
// Ports: none (package).

package encoder_pkg;

    // 2-bit direction code as produced by the quadrature decoder.
    typedef logic [1:0] dir_code_t;

    localparam dir_code_t DIR_IDLE = 2'b00;
    localparam dir_code_t DIR_CW   = 2'b01;
    localparam dir_code_t DIR_CCW  = 2'b10;
    localparam dir_code_t DIR_INV  = 2'b11;

    // True for the two codes that represent real motion.
    function automatic logic dir_is_move(input dir_code_t code);
        return (code == DIR_CW) || (code == DIR_CCW);
    endfunction

endpackage

// File: rtl/encoder_velocity_window.sv
// rtl/encoder_velocity_window.sv - windowed net-step counter producing signed velocity
//
// Purpose: counts net signed steps over a free-running window of WINDOW clk
// cycles and publishes the total once per window.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   step_ev     - one step accepted this cycle
//   step_cw     - sign of that step (1 = CW/+1, 0 = CCW/-1)
//   velocity    - signed net steps of the last complete window
//   vel_valid   - one-cycle pulse when velocity updates

module encoder_velocity_window #(
    parameter int WINDOW = 1000,
    parameter int VEL_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    step_ev,
    input  logic                    step_cw,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    vel_valid
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W-1:0] VEL_ONE = {{(VEL_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [VEL_W-1:0] acc_q, acc_d;
    logic signed [VEL_W-1:0] velocity_q, velocity_d;
    logic                    vel_valid_q, vel_valid_d;
    logic signed [VEL_W-1:0] acc_next;

    always_comb begin
        // Accumulate this cycle's step first so the closing cycle of a window
        // still includes its own step in the published total.
        acc_next = acc_q;
        if (step_ev) begin
            if (step_cw) begin
                acc_next = (acc_q == VEL_MAX) ? acc_q : acc_q + VEL_ONE;
            end else begin
                acc_next = (acc_q == VEL_MIN) ? acc_q : acc_q - VEL_ONE;
            end
        end

        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
        acc_d       = acc_next;
        velocity_d  = velocity_q;
        vel_valid_d = 1'b0;

        if (cnt_q == CNT_LAST) begin
            velocity_d  = acc_next;
            acc_d       = '0;
            vel_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            velocity_q  <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            velocity_q  <= velocity_d;
            vel_valid_q <= vel_valid_d;
        end
    end

    assign velocity  = velocity_q;
    assign vel_valid = vel_valid_q;

endmodule

// File: rtl/encoder_position_tracker.sv
// rtl/encoder_position_tracker.sv - absolute position, step pulses, velocity and error from decoder codes
//
// Purpose: converts the decoder's 2-bit direction code into step events,
// tracks a signed absolute position (clear/load/saturate-or-wrap) and
// reports windowed velocity plus sticky error/overflow flags.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   dir                 - direction code (00 idle, 01 CW, 10 CCW, 11 invalid)
//   clear               - position, err, overflow to 0
//   load, load_val      - preset position
//   position            - signed absolute position
//   step, step_dir      - accepted-step pulse and direction of last step
//   velocity, vel_valid - net steps per window and its update pulse
//   err, overflow       - sticky invalid-code and position-limit flags

module encoder_position_tracker
    import encoder_pkg::*;
#(
    parameter int POS_W    = 16,
    parameter int VEL_W    = 12,
    parameter int WINDOW   = 1000,
    parameter int SATURATE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              dir,
    input  logic                    clear,
    input  logic                    load,
    input  logic signed [POS_W-1:0] load_val,
    output logic signed [POS_W-1:0] position,
    output logic                    step,
    output logic                    step_dir,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    vel_valid,
    output logic                    err,
    output logic                    overflow
);

    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    dir_code_t               dir_q, dir_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    step_q, step_d;
    logic                    step_dir_q, step_dir_d;
    logic                    err_q, err_d;
    logic                    ovf_q, ovf_d;

    logic step_ev;
    logic step_cw;
    logic inv_ev;

    // A code counts only on its first cycle; holding it does not re-step,
    // and a direct CW<->CCW change is a fresh step.
    assign step_ev = dir_is_move(dir) && (dir != dir_q);
    assign step_cw = (dir == DIR_CW);
    assign inv_ev  = (dir == DIR_INV) && (dir_q != DIR_INV);

    always_comb begin
        dir_d      = dir;
        pos_d      = pos_q;
        step_d     = step_ev;
        step_dir_d = step_ev ? step_cw : step_dir_q;
        err_d      = err_q | inv_ev;
        ovf_d      = ovf_q;

        // clear/load override a coincident step for position only; the step
        // still pulses and still reaches the velocity window.
        if (clear) begin
            pos_d = '0;
            err_d = 1'b0;
            ovf_d = 1'b0;
        end else if (load) begin
            pos_d = load_val;
        end else if (step_ev) begin
            if (step_cw) begin
                if (pos_q == POS_MAX) begin
                    ovf_d = 1'b1;
                    pos_d = (SATURATE != 0) ? pos_q : POS_MIN;
                end else begin
                    pos_d = pos_q + POS_ONE;
                end
            end else begin
                if (pos_q == POS_MIN) begin
                    ovf_d = 1'b1;
                    pos_d = (SATURATE != 0) ? pos_q : POS_MAX;
                end else begin
                    pos_d = pos_q - POS_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= DIR_IDLE;
            pos_q      <= '0;
            step_q     <= 1'b0;
            step_dir_q <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            step_dir_q <= step_dir_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    encoder_velocity_window #(
        .WINDOW (WINDOW),
        .VEL_W  (VEL_W)
    ) u_vel (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_ev   (step_ev),
        .step_cw   (step_cw),
        .velocity  (velocity),
        .vel_valid (vel_valid)
    );

    assign position = pos_q;
    assign step     = step_q;
    assign step_dir = step_dir_q;
    assign err      = err_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_encoder_position_tracker.sv
// tb/tb_encoder_position_tracker.sv - directed self-checking bench for encoder_position_tracker

module tb_encoder_position_tracker;

    localparam int POS_W  = 16;
    localparam int VEL_W  = 12;
    localparam int WINDOW = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       dir;
    logic             clear;
    logic             load;
    logic [POS_W-1:0] load_val;

    logic [POS_W-1:0] position,  w_position;
    logic             step,      w_step;
    logic             step_dir,  w_step_dir;
    logic [VEL_W-1:0] velocity,  w_velocity;
    logic             vel_valid, w_vel_valid;
    logic             err,       w_err;
    logic             overflow,  w_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    encoder_position_tracker #(
        .POS_W(POS_W), .VEL_W(VEL_W), .WINDOW(WINDOW), .SATURATE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .position(position), .step(step),
        .step_dir(step_dir), .velocity(velocity), .vel_valid(vel_valid),
        .err(err), .overflow(overflow)
    );

    encoder_position_tracker #(
        .POS_W(POS_W), .VEL_W(VEL_W), .WINDOW(WINDOW), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .position(w_position), .step(w_step),
        .step_dir(w_step_dir), .velocity(w_velocity), .vel_valid(w_vel_valid),
        .err(w_err), .overflow(w_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] d, input logic c, input logic l, input logic [POS_W-1:0] lv);
        dir      = d;
        clear    = c;
        load     = l;
        load_val = lv;
        tick();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        dir      = 2'b00;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] t1_dir  [6];
        logic       t1_step [6];
        logic [1:0] t5_dir  [10];

        t1_dir  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
        t1_step = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        t5_dir  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};

        // Reset state
        do_reset();
        check_eq("rst_position",  32'(position),  32'h0);
        check_eq("rst_step",      32'(step),      32'h0);
        check_eq("rst_step_dir",  32'(step_dir),  32'h0);
        check_eq("rst_velocity",  32'(velocity),  32'h0);
        check_eq("rst_vel_valid", 32'(vel_valid), 32'h0);
        check_eq("rst_err",       32'(err),       32'h0);
        check_eq("rst_overflow",  32'(overflow),  32'h0);

        // 1: held code counts once
        for (int i = 0; i < 6; i++) begin
            apply(t1_dir[i], 1'b0, 1'b0, '0);
            check_eq($sformatf("t1_step_%0d", i), 32'(step), 32'(t1_step[i]));
        end
        check_eq("t1_position", 32'(position), 32'h2);
        check_eq("t1_step_dir", 32'(step_dir), 32'h1);

        // 2: alternating CW/CCW from 5
        apply(2'b00, 1'b0, 1'b1, 16'd5);
        check_eq("t2_load", 32'(position), 32'h5);
        for (int i = 0; i < 4; i++) begin
            apply((i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, '0);
            check_eq($sformatf("t2_pos_%0d", i), 32'(position), (i % 2 == 0) ? 32'h6 : 32'h5);
            check_eq($sformatf("t2_step_%0d", i), 32'(step), 32'h1);
        end
        check_eq("t2_step_dir", 32'(step_dir), 32'h0);

        // 3: max positive limit, saturate vs wrap
        apply(2'b00, 1'b0, 1'b1, 16'h7FFF);
        check_eq("t3_ovf_pre", 32'(overflow), 32'h0);
        apply(2'b01, 1'b0, 1'b0, '0);
        check_eq("t3_sat_pos",  32'(position),   32'h7FFF);
        check_eq("t3_sat_ovf",  32'(overflow),   32'h1);
        check_eq("t3_wrap_pos", 32'(w_position), 32'h8000);
        check_eq("t3_wrap_ovf", 32'(w_overflow), 32'h1);
        // min negative limit
        apply(2'b00, 1'b1, 1'b0, '0);
        check_eq("t3_clr_ovf", 32'(overflow), 32'h0);
        apply(2'b00, 1'b0, 1'b1, 16'h8000);
        apply(2'b10, 1'b0, 1'b0, '0);
        check_eq("t3_sat_min_pos",  32'(position),   32'h8000);
        check_eq("t3_sat_min_ovf",  32'(overflow),   32'h1);
        check_eq("t3_wrap_min_pos", 32'(w_position), 32'h7FFF);
        check_eq("t3_wrap_min_ovf", 32'(w_overflow), 32'h1);

        // 4: invalid code sets sticky err
        apply(2'b00, 1'b0, 1'b0, '0);
        apply(2'b11, 1'b0, 1'b0, '0);
        check_eq("t4_err",      32'(err),      32'h1);
        check_eq("t4_position", 32'(position), 32'h8000);
        check_eq("t4_step",     32'(step),     32'h0);
        apply(2'b00, 1'b0, 1'b0, '0);
        check_eq("t4_err_sticky", 32'(err), 32'h1);
        apply(2'b00, 1'b1, 1'b0, '0);
        check_eq("t4_clr_err", 32'(err),      32'h0);
        check_eq("t4_clr_pos", 32'(position), 32'h0);

        // 5: velocity window, 3 CW + 1 CCW then an empty window
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            apply(t5_dir[k-1], 1'b0, 1'b0, '0);
            check_eq($sformatf("t5_vv_%0d", k), 32'(vel_valid), (k == 10) ? 32'h1 : 32'h0);
        end
        check_eq("t5_velocity", 32'(velocity), 32'h2);
        apply(2'b00, 1'b0, 1'b0, '0);
        check_eq("t5_vv_11", 32'(vel_valid), 32'h0);
        for (int k = 12; k <= 20; k++) apply(2'b00, 1'b0, 1'b0, '0);
        check_eq("t5_vv_20",       32'(vel_valid), 32'h1);
        check_eq("t5_velocity_w2", 32'(velocity),  32'h0);

        // 6: load coincident with step, then async reset mid-window
        do_reset();
        apply(2'b01, 1'b0, 1'b1, 16'hFFFC);
        check_eq("t6_position", 32'(position), 32'hFFFC);
        check_eq("t6_step",     32'(step),     32'h1);
        for (int k = 2; k <= 10; k++) apply(2'b00, 1'b0, 1'b0, '0);
        check_eq("t6_vv",       32'(vel_valid), 32'h1);
        check_eq("t6_velocity", 32'(velocity),  32'h1);
        apply(2'b01, 1'b0, 1'b0, '0);
        check_eq("t6_pos_step", 32'(position), 32'hFFFD);
        apply(2'b00, 1'b0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_position", 32'(position), 32'h0);
        check_eq("t6_rst_velocity", 32'(velocity), 32'h0);
        check_eq("t6_rst_step_dir", 32'(step_dir), 32'h0);
        check_eq("t6_rst_step",     32'(step),     32'h0);
        check_eq("t6_rst_err",      32'(err),      32'h0);
        check_eq("t6_rst_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) apply(2'b00, 1'b0, 1'b0, '0);
        check_eq("t6_vv_9", 32'(vel_valid), 32'h0);
        apply(2'b00, 1'b0, 1'b0, '0);
        check_eq("t6_vv_10",       32'(vel_valid), 32'h1);
        check_eq("t6_velocity_rs", 32'(velocity),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_position_tracker.md
Name: encoder_position_tracker

Overview:
Downstream consumer of the quadrature direction decoder. Turns its 2-bit direction code into signed step events and keeps an absolute position count (load/clear). Also produces a windowed velocity measurement and a sticky error flag. Feeds motor-control and display logic with position and speed.

Parameters:
POS_W, 16, width of signed position counter
VEL_W, 12, width of signed velocity output
WINDOW, 1000, velocity measurement window in clk cycles (>=2)
SATURATE, 1, 1 = position saturates at signed min/max, 0 = two's-complement wrap

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dir  in  2  direction code from decoder: 00 idle, 01 CW, 10 CCW, 11 invalid
clear  in  1  synchronous: position <= 0, err <= 0
load  in  1  synchronous: position <= load_val
load_val  in  POS_W  signed preset value
position  out  POS_W  signed absolute position
step  out  1  one-cycle pulse per accepted step
step_dir  out  1  direction of last accepted step (1 = CW, 0 = CCW)
velocity  out  VEL_W  signed net steps in last complete window
vel_valid  out  1  one-cycle pulse when velocity updates
err  out  1  sticky, set on invalid code
overflow  out  1  sticky, set when position saturates/wraps

Behaviour:
- Single clock domain `clk`. Reset is asynchronous and active-low on `rst_n`. Reset values: all outputs 0, dir_q 00, window counter 0, accumulator 0.
- Register dir_q <= dir every cycle.
- Step event: dir in {01,10} and dir != dir_q. A code held for several cycles counts once. 01->10 directly counts one CCW step.
- dir = 11 with dir_q != 11: err <= 1, no step, dir_q still updates. err clears only on clear or reset.
- Latency: dir sampled at edge N; position, step and step_dir are valid after edge N (one-cycle latency from dir presentation).
- Position update priority, highest first:
  - clear: position <= 0, err <= 0, overflow <= 0.
  - load: position <= load_val.
  - step: CW +1, CCW -1.
  - Otherwise hold.
- A step coinciding with clear or load is dropped from position. It still counts toward velocity, and step still pulses.
- SATURATE = 1: at max positive a CW step holds the value and sets overflow. At min negative a CCW step does the same.
- SATURATE = 0: the counter wraps and sets overflow on wrap.
- Velocity window:
  - Window counter runs 0..WINDOW-1 continuously; it is unaffected by clear and load.
  - Accumulator is signed VEL_W, adds +1 or -1 per step event, and saturates at the VEL_W signed limits.
  - On the cycle the counter equals WINDOW-1: velocity <= acc + current step contribution (saturated), acc <= 0, vel_valid = 1 for that cycle.
  - First vel_valid comes WINDOW cycles after reset release.
- Reset mid-window or mid-step discards the partial window.

Decomposition:
- Shared package encoder_pkg:
  - DIR_IDLE = 2'b00, DIR_CW = 2'b01, DIR_CCW = 2'b10, DIR_INV = 2'b11.
  - A typedef for the 2-bit direction code, shared with the decoder.
- One sub-module: encoder_velocity_window.
  - Inputs: step event and sign.
  - Outputs: velocity and vel_valid.
  - Parameters: WINDOW and VEL_W.
  - Owns the window counter and accumulator.

Test Plan:
1. Reset, then dir 00->01->01->01->00->01 -> step pulses twice, position = 2, step_dir = 1.
2. Alternate dir 01,10,01,10 (one cycle each) from position 5 -> 5,6,5,6,5 after each edge; four step pulses.
3. SATURATE = 1, load_val = 16'h7FFF via load, then one CW step -> position stays 7FFF, overflow = 1. Repeat with SATURATE = 0 -> position = 8000, overflow = 1.
4. dir = 11 for one cycle -> err = 1, position unchanged; err stays set until clear, then clear -> position 0, err 0.
5. WINDOW = 10, inject 3 CW and 1 CCW steps within the first window -> vel_valid at cycle 10 with velocity = 2. An empty next window -> velocity = 0.
6. Assert load (load_val = -4) on the same cycle as a CW step -> position = -4, step = 1, next velocity includes +1; assert rst_n low mid-window -> all outputs 0 immediately.
